// File: rtl/corr_iq_frame_capture.sv
// corr_iq_frame_capture: captures chirp-aligned ADC/DAC IQ pairs into a
// frame buffer and replays them as a framed AXI-Stream toward the matched
// filter. Optional zero padding per frame is enabled by CORR_ZERO_PAD_EN.
module corr_iq_frame_capture #(
    parameter int FFT_LEN     = 4096,
    parameter int CAPTURE_LEN = 2048,
    parameter int FIFO_DEPTH  = 8192
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [31:0]                   adc_iq_in,
    input  logic [31:0]                   dac_iq_in,
    input  logic                          sample_valid,
    input  logic                          chirp_active,
    input  logic                          adc_enable,
    output logic [31:0]                   adc_iq_tdata,
    output logic [31:0]                   dac_iq_tdata,
    output logic                          iq_tvalid,
    output logic                          iq_tlast,
    output logic                          iq_first,
    input  logic                          iq_tready,
    output logic [63:0]                   counter_id,
    output logic                          capture_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   skipped_chirps
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(FFT_LEN);

`ifdef CORR_ZERO_PAD_EN
    localparam int NCAP = CAPTURE_LEN;
`else
    localparam int NCAP = FFT_LEN;
`endif

    localparam bit CFG_OK = (CAPTURE_LEN >= 1) &&
                            (CAPTURE_LEN <= FFT_LEN) &&
                            (FIFO_DEPTH >= FFT_LEN);

    localparam logic [LW-1:0] DEPTH_W = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] N_LW    = LW'(NCAP);
    localparam logic [BW:0]   N_BW    = (BW+1)'(NCAP);
    localparam logic [BW-1:0] LAST_B  = BW'(FFT_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_CAPTURE
    } state_t;

    // Capture side
    state_t         state_q;
    logic [BW:0]    wcnt_q;
    logic [BW:0]    wcnt_d;
    logic           chirp_d_q;
    logic [15:0]    skip_q;
    logic           trig;
    logic           room;
    logic           start;
    logic           wr_en;

    // Buffer
    logic [63:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wptr_q;
    logic [AW-1:0]  rptr_q;
    logic [LW-1:0]  level_q;
    logic [LW-1:0]  level_d;
    logic [63:0]    rd_data;
    logic           nonempty;
    logic           rd_en;

    // Output stage
    logic [31:0]    adc_q;
    logic [31:0]    dac_q;
    logic           vld_q;
    logic [BW-1:0]  b_q;
    logic [63:0]    cid_q;
    logic           hs;
    logic           out_free;
    logic           zero_nb;
    logic           avail;

    assign trig  = chirp_active & ~chirp_d_q & adc_enable;
    // Room is judged on the registered level, so a same-cycle read
    // never counts toward the reservation.
    assign room  = (DEPTH_W - level_q) >= N_LW;
    assign start = trig & room & (state_q == S_IDLE);
    assign wr_en = sample_valid & ((state_q == S_CAPTURE) | start);

    assign wcnt_d = ((state_q == S_IDLE) ? '0 : wcnt_q) +
                    {{BW{1'b0}}, wr_en};

    // Capture FSM: arms on an accepted trigger, ends after NCAP writes
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            chirp_d_q <= 1'b0;
            skip_q    <= '0;
        end else begin
            chirp_d_q <= chirp_active;
            if (trig && !start && skip_q != 16'hFFFF) begin
                skip_q <= skip_q + 16'd1;
            end
            if (state_q == S_CAPTURE || start) begin
                if (wcnt_d == N_BW) begin
                    state_q <= S_IDLE;
                    wcnt_q  <= '0;
                end else begin
                    state_q <= S_CAPTURE;
                    wcnt_q  <= wcnt_d;
                end
            end
        end
    end

    assign nonempty = level_q != '0;
    assign rd_data  = mem_q[rptr_q];
    assign level_d  = level_q + LW'(wr_en) - LW'(rd_en);

    // Sample-pair storage; contents are meaningless once pointers reset
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= {adc_iq_in, dac_iq_in};
        end
    end

    // Buffer pointers and occupancy; reset flushes the buffer
    always_ff @(posedge aclk) begin
        if (areset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_en) begin
                rptr_q <= rptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    assign hs       = vld_q & iq_tready;
    assign out_free = ~vld_q | iq_tready;

`ifdef CORR_ZERO_PAD_EN
    logic [BW-1:0] nb;
    // Index of the beat that would be loaded next
    assign nb = vld_q ? ((b_q == LAST_B) ? '0 : b_q + BW'(1)) : b_q;
    assign zero_nb = {1'b0, nb} >= N_BW;
`else
    assign zero_nb = 1'b0;
`endif

    assign avail = zero_nb | nonempty;
    assign rd_en = out_free & ~zero_nb & nonempty;

    // Registered output stage with beat counter and frame id
    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_q <= 1'b0;
            adc_q <= '0;
            dac_q <= '0;
            b_q   <= '0;
            cid_q <= '0;
        end else begin
            if (hs) begin
                if (b_q == LAST_B) begin
                    b_q   <= '0;
                    cid_q <= cid_q + 64'd1;
                end else begin
                    b_q <= b_q + BW'(1);
                end
            end
            if (out_free) begin
                vld_q <= avail;
                if (avail) begin
                    adc_q <= zero_nb ? 32'd0 : rd_data[63:32];
                    dac_q <= zero_nb ? 32'd0 : rd_data[31:0];
                end
            end
        end
    end

    // Guard against a write into a full buffer and bad parameters
    always_ff @(posedge aclk) begin
        if (!areset) begin
            assert (!(wr_en && level_q == DEPTH_W))
            else $error("frame buffer written while full");
            assert (CFG_OK)
            else $error("illegal frame capture parameters");
        end
    end

    assign adc_iq_tdata   = adc_q;
    assign dac_iq_tdata   = dac_q;
    assign iq_tvalid      = vld_q;
    assign iq_first       = (b_q == '0);
    assign iq_tlast       = (b_q == LAST_B);
    assign counter_id     = cid_q;
    assign capture_busy   = (state_q == S_CAPTURE);
    assign fifo_level     = level_q;
    assign skipped_chirps = skip_q;

endmodule

// File: tb/tb_corr_iq_frame_capture.sv
// Directed bench for corr_iq_frame_capture with FFT_LEN=16, FIFO_DEPTH=32.
// Expectations follow CORR_ZERO_PAD_EN when it is defined for the build.
module tb_corr_iq_frame_capture;

    localparam int FFT   = 16;
    localparam int CAP   = 10;
    localparam int DEPTH = 32;
`ifdef CORR_ZERO_PAD_EN
    localparam int N = CAP;
`else
    localparam int N = FFT;
`endif
    localparam int NTRIG = DEPTH / N + 1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        f;
        logic        l;
        logic [63:0] c;
    } beat_t;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] adc_in = '0;
    logic [31:0] dac_in = '0;
    logic        svld = 1'b0;
    logic        chirp = 1'b0;
    logic        en = 1'b0;
    logic        tready = 1'b1;
    logic [31:0] adc_o;
    logic [31:0] dac_o;
    logic        tvalid;
    logic        tlast;
    logic        first;
    logic [63:0] cid;
    logic        busy;
    logic [5:0]  level;
    logic [15:0] skipped;

    int    checks = 0;
    int    errors = 0;
    int    peak = 0;
    beat_t rec[$];
    beat_t prev;
    logic  stall = 1'b0;

    corr_iq_frame_capture #(
        .FFT_LEN(FFT),
        .CAPTURE_LEN(CAP),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .aclk(clk),
        .areset(areset),
        .adc_iq_in(adc_in),
        .dac_iq_in(dac_in),
        .sample_valid(svld),
        .chirp_active(chirp),
        .adc_enable(en),
        .adc_iq_tdata(adc_o),
        .dac_iq_tdata(dac_o),
        .iq_tvalid(tvalid),
        .iq_tlast(tlast),
        .iq_first(first),
        .iq_tready(tready),
        .counter_id(cid),
        .capture_busy(busy),
        .fifo_level(level),
        .skipped_chirps(skipped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sa(input int f, input int k);
        return {16'hA000 + 16'(f), 16'h0100 + 16'(k)};
    endfunction

    function automatic logic [31:0] sd(input int f, input int k);
        return {16'hD000 + 16'(f), 16'h0200 + 16'(k)};
    endfunction

    function automatic beat_t exp_beat(input int f, input int k,
                                       input logic [63:0] c);
        beat_t e;
        e.a = (k < N) ? sa(f, k) : 32'd0;
        e.d = (k < N) ? sd(f, k) : 32'd0;
        e.f = (k == 0);
        e.l = (k == FFT - 1);
        e.c = c;
        return e;
    endfunction

    // Beat recorder, stall-stability monitor and level peak tracker
    always @(negedge clk) begin
        beat_t cur;
        cur = '{a: adc_o, d: dac_o, f: first, l: tlast, c: cid};
        if (areset) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_hold", cur, prev);
            end
            if (tvalid && tready) begin
                rec.push_back(cur);
            end
            stall = tvalid && !tready;
            prev  = cur;
            if (int'(level) > peak) begin
                peak = int'(level);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        svld   = 1'b0;
        chirp  = 1'b0;
        adc_in = '0;
        dac_in = '0;
    endtask

    task automatic feed(input int f, input logic [15:0] rpat,
                        input logic usepat);
        for (int k = 0; k < FFT; k++) begin
            chirp  = 1'b1;
            en     = 1'b1;
            svld   = 1'b1;
            adc_in = sa(f, k);
            dac_in = sd(f, k);
            if (usepat) begin
                tready = rpat[k];
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (rec.size() < n && t < 400) begin
            step();
            t++;
        end
        chk("beat_count", 160'(rec.size()), 160'(n));
    endtask

    task automatic check_frame(input int off, input int f,
                               input logic [63:0] c);
        beat_t got;
        for (int k = 0; k < FFT; k++) begin
            got = (off + k < rec.size()) ? rec[off + k] : '0;
            chk($sformatf("f%0d_beat%0d", f, k), got, exp_beat(f, k, c));
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_tvalid", 160'(tvalid), 160'(0));
        chk("rst_tlast", 160'(tlast), 160'(0));
        chk("rst_first", 160'(first), 160'(1));
        chk("rst_cid", 160'(cid), 160'(0));
        chk("rst_level", 160'(level), 160'(0));
        chk("rst_skip", 160'(skipped), 160'(0));
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_data", {adc_o, dac_o}, 160'(0));
        areset = 1'b0;
        step();

        // Frame 0: latency and ordering with tready held high
        rec.delete();
        tready = 1'b1;
        for (int k = 0; k < FFT; k++) begin
            chirp  = 1'b1;
            en     = 1'b1;
            svld   = 1'b1;
            adc_in = sa(0, k);
            dac_in = sd(0, k);
            step();
            if (k == 0) begin
                chk("lat_busy", 160'(busy), 160'(1));
                chk("lat_t1_tvalid", 160'(tvalid), 160'(0));
            end
            if (k == 1) begin
                chk("lat_t2_tvalid", 160'(tvalid), 160'(1));
                chk("lat_t2_first", 160'(first), 160'(1));
                chk("lat_t2_adc", 160'(adc_o), 160'(sa(0, 0)));
            end
        end
        idle_inputs();
        step();
        wait_beats(FFT);
        check_frame(0, 0, 64'd0);
        chk("f0_busy_done", 160'(busy), 160'(0));

        // Frame 1: fixed irregular tready pattern during capture
        rec.delete();
        peak = 0;
        feed(1, 16'b1011_0010_1100_1101, 1'b1);
        tready = 1'b1;
        wait_beats(FFT);
        check_frame(0, 1, 64'd1);
        chk("f1_peak_level", 160'(peak <= N), 160'(1));

        // Stalled output: frames fill the buffer until one is rejected
        rec.delete();
        tready = 1'b0;
        for (int t = 0; t < NTRIG; t++) begin
            feed(2 + t, 16'h0000, 1'b1);
        end
        chk("ovf_skip", 160'(skipped), 160'(1));
        chk("ovf_level", 160'(level), 160'((NTRIG - 1) * N - 1));
        chk("ovf_hold_valid", 160'(tvalid), 160'(1));
        chk("ovf_hold_adc", 160'(adc_o), 160'(sa(2, 0)));
        tready = 1'b1;
        wait_beats((NTRIG - 1) * FFT);
        for (int t = 0; t < NTRIG - 1; t++) begin
            check_frame(t * FFT, 2 + t, 64'(2 + t));
        end
        chk("ovf_level_drained", 160'(level), 160'(0));

        // Retrigger during capture, and an edge with adc_enable low
        rec.delete();
        for (int k = 0; k < FFT; k++) begin
            chirp  = !(k == 5 || k == 9);
            en     = (k < 8);
            svld   = 1'b1;
            adc_in = sa(10, k);
            dac_in = sd(10, k);
            step();
        end
        idle_inputs();
        en = 1'b1;
        step();
        wait_beats(FFT);
        check_frame(0, 10, 64'(1 + NTRIG));
        chk("retrig_skip", 160'(skipped), 160'(2));

        // Reset while output beat 7 is presented
        rec.delete();
        tready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chirp  = 1'b1;
            en     = 1'b1;
            svld   = 1'b1;
            adc_in = sa(11, k);
            dac_in = sd(11, k);
            step();
        end
        chk("mid_beat7_adc", 160'(adc_o), 160'(sa(11, 7)));
        chk("mid_beat7_first", 160'(first), 160'(0));
        adc_in = sa(11, 9);
        dac_in = sd(11, 9);
        areset = 1'b1;
        step();
        chk("mid_rst_tvalid", 160'(tvalid), 160'(0));
        chk("mid_rst_cid", 160'(cid), 160'(0));
        chk("mid_rst_level", 160'(level), 160'(0));
        chk("mid_rst_first", 160'(first), 160'(1));
        chk("mid_rst_skip", 160'(skipped), 160'(0));
        areset = 1'b0;
        idle_inputs();
        step();
        rec.delete();

        // Clean frame after reset starts at beat 0 with id 0
        feed(12, 16'h0000, 1'b0);
        wait_beats(FFT);
        check_frame(0, 12, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
